// File: rtl/writeback_arbiter.sv
// Writeback stage: per-unit result FIFOs (alu, mem, mul) drained round-robin into the register bank.
// Optional WB_BYPASS_EN: when every FIFO is empty, a valid input is written straight to the output register.
module writeback_arbiter #(
  parameter int FIFO_DEPTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alu_wb_oper,
  input  logic                      alu_wb_writereg,
  input  logic [REG_ADDR_WIDTH-1:0] alu_wb_regdest,
  input  logic [DATA_WIDTH-1:0]     alu_wb_wbvalue,
  input  logic                      mem_wb_oper,
  input  logic                      mem_wb_writereg,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wb_regdest,
  input  logic [DATA_WIDTH-1:0]     mem_wb_wbvalue,
  input  logic                      mul_wb_oper,
  input  logic                      mul_wb_writereg,
  input  logic [REG_ADDR_WIDTH-1:0] mul_wb_regdest,
  input  logic [DATA_WIDTH-1:0]     mul_wb_wbvalue,
  output logic                      wb_alu_stall,
  output logic                      wb_mem_stall,
  output logic                      wb_mul_stall,
  output logic                      wb_rb_writeenable,
  output logic [REG_ADDR_WIDTH-1:0] wb_rb_regdest,
  output logic [DATA_WIDTH-1:0]     wb_rb_value,
  output logic                      wb_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = REG_ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {U_ALU = 2'd0, U_MEM = 2'd1, U_MUL = 2'd2} unit_e;

  function automatic unit_e rr_next(input unit_e u);
    case (u)
      U_ALU:   return U_MEM;
      U_MEM:   return U_MUL;
      default: return U_ALU;
    endcase
  endfunction

  logic [2:0]    in_valid;
  logic [EW-1:0] in_entry [3];

  assign in_valid[0] = alu_wb_oper & alu_wb_writereg & (alu_wb_regdest != '0);
  assign in_valid[1] = mem_wb_oper & mem_wb_writereg & (mem_wb_regdest != '0);
  assign in_valid[2] = mul_wb_oper & mul_wb_writereg & (mul_wb_regdest != '0);
  assign in_entry[0] = {alu_wb_regdest, alu_wb_wbvalue};
  assign in_entry[1] = {mem_wb_regdest, mem_wb_wbvalue};
  assign in_entry[2] = {mul_wb_regdest, mul_wb_wbvalue};

  logic [EW-1:0] fifo_mem [3][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [3];
  logic [PW-1:0] rd_ptr [3];
  logic [CW-1:0] count [3];
  logic [CW-1:0] count_next [3];
  logic [2:0]    stall_q;
  unit_e         last_q;

  logic [2:0]    non_empty, push, accept, pop;
  logic          grant_valid, byp_valid, drop;
  unit_e         grant, byp_unit, cand;
  logic [EW-1:0] grant_entry;

  always_comb begin
    grant_valid = 1'b0;
    grant       = U_ALU;
    cand        = last_q;
    for (int unsigned u = 0; u < 3; u++) non_empty[u] = (count[u] != '0);
    for (int unsigned k = 0; k < 3; k++) begin
      cand = rr_next(cand);
      if (!grant_valid && non_empty[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
    grant_entry = fifo_mem[grant][rd_ptr[grant]];
  end

  // Bypass only fires when no FIFO holds anything, so it never competes with a FIFO grant.
  always_comb begin
    byp_valid = 1'b0;
    byp_unit  = U_ALU;
`ifdef WB_BYPASS_EN
    begin
      unit_e bc;
      bc = last_q;
      for (int unsigned k = 0; k < 3; k++) begin
        bc = rr_next(bc);
        if (!byp_valid && (non_empty == '0) && in_valid[bc]) begin
          byp_valid = 1'b1;
          byp_unit  = bc;
        end
      end
    end
`endif
  end

  always_comb begin
    drop = 1'b0;
    for (int unsigned u = 0; u < 3; u++) begin
      pop[u]    = grant_valid && (grant == unit_e'(u));
      push[u]   = in_valid[u] && !(byp_valid && (byp_unit == unit_e'(u)));
      // A full FIFO still takes a push when the same edge pops it.
      accept[u] = push[u] && ((count[u] != CW'(FIFO_DEPTH)) || pop[u]);
      drop      = drop | (push[u] & ~accept[u]);
      count_next[u] = count[u] + {{PW{1'b0}}, accept[u]} - {{PW{1'b0}}, pop[u]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned u = 0; u < 3; u++) begin
        wr_ptr[u] <= '0;
        rd_ptr[u] <= '0;
        count[u]  <= '0;
      end
      stall_q           <= '0;
      last_q            <= U_MUL;
      wb_rb_writeenable <= 1'b0;
      wb_rb_regdest     <= '0;
      wb_rb_value       <= '0;
      wb_overflow       <= 1'b0;
    end else begin
      for (int unsigned u = 0; u < 3; u++) begin
        if (accept[u]) begin
          fifo_mem[u][wr_ptr[u]] <= in_entry[u];
          wr_ptr[u]              <= wr_ptr[u] + 1'b1;
        end
        if (pop[u]) rd_ptr[u] <= rd_ptr[u] + 1'b1;
        count[u]   <= count_next[u];
        stall_q[u] <= (count_next[u] >= CW'(FIFO_DEPTH - 1));
      end
      wb_rb_writeenable <= grant_valid | byp_valid;
      if (grant_valid) begin
        {wb_rb_regdest, wb_rb_value} <= grant_entry;
        last_q                       <= grant;
      end else if (byp_valid) begin
        {wb_rb_regdest, wb_rb_value} <= in_entry[byp_unit];
        last_q                       <= byp_unit;
      end
      wb_overflow <= wb_overflow | drop;
    end
  end

  assign wb_alu_stall = stall_q[0];
  assign wb_mem_stall = stall_q[1];
  assign wb_mul_stall = stall_q[2];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (default build; WB_BYPASS_EN shifts latency by one).
module tb_writeback_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        alu_wb_oper, alu_wb_writereg, mem_wb_oper, mem_wb_writereg, mul_wb_oper, mul_wb_writereg;
  logic [4:0]  alu_wb_regdest, mem_wb_regdest, mul_wb_regdest;
  logic [31:0] alu_wb_wbvalue, mem_wb_wbvalue, mul_wb_wbvalue;
  logic        wb_alu_stall, wb_mem_stall, wb_mul_stall, wb_rb_writeenable, wb_overflow;
  logic [4:0]  wb_rb_regdest;
  logic [31:0] wb_rb_value;

  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.FIFO_DEPTH(4), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .alu_wb_oper(alu_wb_oper), .alu_wb_writereg(alu_wb_writereg),
    .alu_wb_regdest(alu_wb_regdest), .alu_wb_wbvalue(alu_wb_wbvalue),
    .mem_wb_oper(mem_wb_oper), .mem_wb_writereg(mem_wb_writereg),
    .mem_wb_regdest(mem_wb_regdest), .mem_wb_wbvalue(mem_wb_wbvalue),
    .mul_wb_oper(mul_wb_oper), .mul_wb_writereg(mul_wb_writereg),
    .mul_wb_regdest(mul_wb_regdest), .mul_wb_wbvalue(mul_wb_wbvalue),
    .wb_alu_stall(wb_alu_stall), .wb_mem_stall(wb_mem_stall), .wb_mul_stall(wb_mul_stall),
    .wb_rb_writeenable(wb_rb_writeenable), .wb_rb_regdest(wb_rb_regdest),
    .wb_rb_value(wb_rb_value), .wb_overflow(wb_overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    alu_wb_oper = 0; alu_wb_writereg = 0; alu_wb_regdest = 0; alu_wb_wbvalue = 0;
    mem_wb_oper = 0; mem_wb_writereg = 0; mem_wb_regdest = 0; mem_wb_wbvalue = 0;
    mul_wb_oper = 0; mul_wb_writereg = 0; mul_wb_regdest = 0; mul_wb_wbvalue = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    alu_wb_oper = 1; alu_wb_writereg = 1; alu_wb_regdest = 5'd3; alu_wb_wbvalue = 32'h1111_1111;
    mem_wb_oper = 1; mem_wb_writereg = 1; mem_wb_regdest = 5'd4; mem_wb_wbvalue = 32'h2222_2222;
    mul_wb_oper = 1; mul_wb_writereg = 1; mul_wb_regdest = 5'd6; mul_wb_wbvalue = 32'h3333_3333;
    reset = 0;
    tick();
    tick();
    checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", wb_rb_writeenable); end
    checks++; if (wb_rb_regdest !== 5'd0) begin errors++; $display("FAIL reset_regdest got %0d want 0", wb_rb_regdest); end
    checks++; if (wb_rb_value !== 32'd0) begin errors++; $display("FAIL reset_value got %h want 0", wb_rb_value); end
    checks++; if (wb_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", wb_overflow); end
    checks++; if ({wb_alu_stall, wb_mem_stall, wb_mul_stall} !== 3'b000) begin
      errors++; $display("FAIL reset_stalls got %b want 000", {wb_alu_stall, wb_mem_stall, wb_mul_stall});
    end
    clear_inputs();
    reset = 1;
    tick();
    checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL post_reset_we got %b want 0", wb_rb_writeenable); end
  endtask

  task automatic test_single();
    mul_wb_oper = 1; mul_wb_writereg = 1; mul_wb_regdest = 5'd5; mul_wb_wbvalue = 32'hFFFF_FFFA;
    tick();
    clear_inputs();
`ifndef WB_BYPASS_EN
    checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL single_early_we got %b want 0", wb_rb_writeenable); end
    tick();
`endif
    checks++; if (wb_rb_writeenable !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", wb_rb_writeenable); end
    checks++; if (wb_rb_regdest !== 5'd5) begin errors++; $display("FAIL single_regdest got %0d want 5", wb_rb_regdest); end
    checks++; if (wb_rb_value !== 32'hFFFF_FFFA) begin errors++; $display("FAIL single_value got %h want fffffffa", wb_rb_value); end
    tick();
    checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL single_once got %b want 0", wb_rb_writeenable); end
    checks++; if (wb_rb_regdest !== 5'd5) begin errors++; $display("FAIL single_hold got %0d want 5", wb_rb_regdest); end
  endtask

  task automatic test_three_units();
    alu_wb_oper = 1; alu_wb_writereg = 1; alu_wb_regdest = 5'd1; alu_wb_wbvalue = 32'd11;
    mem_wb_oper = 1; mem_wb_writereg = 1; mem_wb_regdest = 5'd2; mem_wb_wbvalue = 32'd22;
    mul_wb_oper = 1; mul_wb_writereg = 1; mul_wb_regdest = 5'd3; mul_wb_wbvalue = 32'd33;
    tick();
    clear_inputs();
`ifndef WB_BYPASS_EN
    checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL three_early_we got %b want 0", wb_rb_writeenable); end
    tick();
`endif
    for (int i = 0; i < 3; i++) begin
      checks++; if (wb_rb_writeenable !== 1'b1 || wb_rb_regdest !== 5'(i + 1) || wb_rb_value !== 32'(11 * (i + 1))) begin
        errors++; $display("FAIL three_order[%0d] got we=%b r%0d=%0d want we=1 r%0d=%0d",
                           i, wb_rb_writeenable, wb_rb_regdest, wb_rb_value, i + 1, 11 * (i + 1));
      end
      tick();
    end
    checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL three_extra_we got %b want 0", wb_rb_writeenable); end
  endtask

  task automatic test_filtered();
    alu_wb_oper = 1; alu_wb_writereg = 1; alu_wb_regdest = 5'd0; alu_wb_wbvalue = 32'hDEAD_0001;
    mem_wb_oper = 1; mem_wb_writereg = 0; mem_wb_regdest = 5'd4; mem_wb_wbvalue = 32'hDEAD_0002;
    mul_wb_oper = 0; mul_wb_writereg = 1; mul_wb_regdest = 5'd6; mul_wb_wbvalue = 32'hDEAD_0003;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL filtered_we[%0d] got %b want 0", i, wb_rb_writeenable); end
    end
    checks++; if ({wb_alu_stall, wb_mem_stall, wb_mul_stall} !== 3'b000) begin
      errors++; $display("FAIL filtered_stalls got %b want 000", {wb_alu_stall, wb_mem_stall, wb_mul_stall});
    end
    clear_inputs();
    tick();
    alu_wb_oper = 1; alu_wb_writereg = 1; alu_wb_regdest = 5'd9; alu_wb_wbvalue = 32'd99;
    tick();
    clear_inputs();
`ifndef WB_BYPASS_EN
    tick();
`endif
    checks++; if (wb_rb_writeenable !== 1'b1 || wb_rb_regdest !== 5'd9 || wb_rb_value !== 32'd99) begin
      errors++; $display("FAIL filtered_follow got we=%b r%0d=%0d want we=1 r9=99", wb_rb_writeenable, wb_rb_regdest, wb_rb_value);
    end
    tick();
    checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL filtered_leftover got %b want 0", wb_rb_writeenable); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] got [$];
    logic [36:0] want;
    apply_reset();
    for (int k = 1; k <= 30; k++) begin
      if (k <= 8) begin
        alu_wb_oper = 1; alu_wb_writereg = 1; alu_wb_regdest = 5'(10 + k - 1); alu_wb_wbvalue = 32'hA000_0000 + 32'(k - 1);
        mul_wb_oper = 1; mul_wb_writereg = 1; mul_wb_regdest = 5'(20 + k - 1); mul_wb_wbvalue = 32'hC000_0000 + 32'(k - 1);
      end else begin
        clear_inputs();
      end
      tick();
      if (wb_rb_writeenable === 1'b1) got.push_back({wb_rb_regdest, wb_rb_value});
`ifndef WB_BYPASS_EN
      if (k == 3) begin
        checks++; if (wb_mul_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_early got %b want 0", wb_mul_stall); end
      end
      if (k == 4) begin
        checks++; if (wb_mul_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_rise got %b want 1", wb_mul_stall); end
      end
`endif
      if (k == 7) begin
        checks++; if (wb_overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow_early got %b want 0", wb_overflow); end
      end
      if (k == 8) begin
        checks++; if (wb_overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow_set got %b want 1", wb_overflow); end
      end
    end
    checks++; if (wb_overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow_sticky got %b want 1", wb_overflow); end
    checks++; if (got.size() != 15) begin errors++; $display("FAIL b2b_write_count got %0d want 15", got.size()); end
    for (int i = 0; i < 15 && i < got.size(); i++) begin
      if (i % 2 == 0) want = {5'(10 + i / 2), 32'hA000_0000 + 32'(i / 2)};
      else            want = {5'(20 + i / 2), 32'hC000_0000 + 32'(i / 2)};
      checks++; if (got[i] !== want) begin errors++; $display("FAIL b2b_write[%0d] got %h want %h", i, got[i], want); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      mul_wb_oper = 1; mul_wb_writereg = 1; mul_wb_regdest = 5'(7 + i); mul_wb_wbvalue = 32'h7700 + 32'(i);
      tick();
    end
    clear_inputs();
    reset = 0;
    tick();
    reset = 1;
    checks++; if (wb_rb_writeenable !== 1'b0 || wb_rb_regdest !== 5'd0 || wb_rb_value !== 32'd0) begin
      errors++; $display("FAIL midreset_outputs got we=%b r%0d=%h want all 0", wb_rb_writeenable, wb_rb_regdest, wb_rb_value);
    end
    checks++; if (wb_overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow got %b want 0", wb_overflow); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL midreset_stale[%0d] got %b want 0", i, wb_rb_writeenable); end
    end
    alu_wb_oper = 1; alu_wb_writereg = 1; alu_wb_regdest = 5'd12; alu_wb_wbvalue = 32'h1234;
    tick();
    clear_inputs();
`ifndef WB_BYPASS_EN
    checks++; if (wb_rb_writeenable !== 1'b0) begin errors++; $display("FAIL midreset_early got %b want 0", wb_rb_writeenable); end
    tick();
`endif
    checks++; if (wb_rb_writeenable !== 1'b1 || wb_rb_regdest !== 5'd12 || wb_rb_value !== 32'h1234) begin
      errors++; $display("FAIL midreset_next got we=%b r%0d=%h want we=1 r12=1234", wb_rb_writeenable, wb_rb_regdest, wb_rb_value);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    test_reset();
    test_single();
    test_three_units();
    test_filtered();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
